// File: rtl/ext_io_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel external IO model.
package ext_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned k = 32'd0; k < 32'd32; k++) begin
      if ((64'd1 << k) < 64'(v)) begin
        r = k + 32'd1;
      end else begin
        r = r;
      end
    end
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

  function automatic int unsigned ctrl_addr(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd4;
  endfunction

  function automatic int unsigned chan_delay(input int unsigned base, input int unsigned i);
    return base * (i + 32'd1);
  endfunction

endpackage

// File: rtl/ext_io_irq_chan.sv
// One-shot interrupt timer: counts while armed, raises pending at the terminal
// count and then stays disarmed until re-armed.
module ext_io_irq_chan #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_arm,
  input  logic             i_ack_sel,
  input  logic [CNT_W-1:0] i_delay_last,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic             r_pending;

  // Counter, armed flag and pending flag; re-arm overrides expiry and ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_armed   <= 1'b1;
      r_pending <= 1'b0;
    end else if (i_arm) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_armed   <= 1'b1;
      r_pending <= 1'b0;
    end else if (r_armed && (r_cnt == i_delay_last)) begin
      r_armed   <= 1'b0;
      r_pending <= 1'b1;
    end else if (r_armed) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (i_ack_sel) begin
      // An armed channel is never pending, so ack only matters once disarmed.
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/external_io_mc.sv
// Byte-addressed big-endian word memory with a fixed-latency read handshake and
// NUM_IRQ one-shot interrupt timers re-armed through a control word.
module external_io_mc
  import ext_io_pkg::*;
#(
  parameter  int ADDR_W    = 12,
  parameter  int RD_LAT    = 2,
  parameter  int NUM_IRQ   = 2,
  parameter  int IRQ_DELAY = 6,
  localparam int ID_W      = clog2_min1(NUM_IRQ)
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     address,
  input  logic [31:0]     in,
  output logic [31:0]     out,
  output logic            rdy,
  output logic            intr,
  output logic [ID_W-1:0] intr_id,
  input  logic            intr_ack
);

  localparam int                MEM_BYTES = 1 << ADDR_W;
  localparam int                LAT_W     = clog2_min1(RD_LAT);
  localparam int                CNT_W     = clog2_min1(IRQ_DELAY * NUM_IRQ);
  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(ctrl_addr(ADDR_W));

  logic [7:0]        r_mem [MEM_BYTES];
  logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic              w_is_ctrl;
  logic              w_wr_acc;
  logic              w_mem_we;
  logic [31:0]       w_rd_word;
  logic              w_unused_addr;

  rd_state_e         r_state, w_state_nx;
  logic [LAT_W-1:0]  r_cnt, w_cnt_nx;
  logic [31:0]       r_hold, w_hold_nx;
  logic [31:0]       r_out, w_out_nx;
  logic              r_rdy, w_rdy_nx;

  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_arm;
  logic [NUM_IRQ-1:0] w_ack_sel;
  logic [ID_W-1:0]    w_id;

  // Byte lanes wrap modulo the memory size through the ADDR_W-bit adder.
  assign w_a0          = address[ADDR_W-1:0];
  assign w_a1          = w_a0 + ADDR_W'(1);
  assign w_a2          = w_a0 + ADDR_W'(2);
  assign w_a3          = w_a0 + ADDR_W'(3);
  assign w_unused_addr = ^address[31:ADDR_W];
  assign w_is_ctrl     = (w_a0 == CTRL_A);
  assign w_wr_acc      = cs & wr;
  assign w_mem_we      = w_wr_acc & ~w_is_ctrl;
  assign w_rd_word     = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

  // Memory array, deliberately not cleared by reset.
  always_ff @(posedge sys_clk) begin
    if (reset && w_mem_we) begin
      r_mem[w_a0] <= in[31:24];
      r_mem[w_a1] <= in[23:16];
      r_mem[w_a2] <= in[15:8];
      r_mem[w_a3] <= in[7:0];
    end
  end

  // Read FSM state and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {LAT_W{1'b0}};
      r_hold  <= 32'h0000_0000;
      r_out   <= 32'h0000_0000;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hold  <= w_hold_nx;
      r_out   <= w_out_nx;
      r_rdy   <= w_rdy_nx;
    end
  end

  // Read FSM next state: data is captured at accept so later writes cannot disturb it.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hold_nx  = r_hold;
    w_out_nx   = r_out;
    w_rdy_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cs && rd && !wr) begin
          w_hold_nx  = w_rd_word;
          w_cnt_nx   = LAT_W'(RD_LAT - 1);
          w_state_nx = ST_WAIT;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == {LAT_W{1'b0}}) begin
          w_state_nx = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt - {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        w_out_nx   = r_hold;
        w_rdy_nx   = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign out = r_out;
  assign rdy = r_rdy;

  // Lowest-index pending channel wins.
  always_comb begin
    w_id = {ID_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_id = ID_W'(i);
      end else begin
        w_id = w_id;
      end
    end
  end

  assign intr    = |w_pending;
  assign intr_id = w_id;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    assign w_arm[g]     = w_wr_acc & w_is_ctrl & in[g];
    assign w_ack_sel[g] = intr_ack & w_pending[g] & (w_id == ID_W'(g));

    ext_io_irq_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .i_clk        (sys_clk),
      .i_rst_n      (reset),
      .i_arm        (w_arm[g]),
      .i_ack_sel    (w_ack_sel[g]),
      .i_delay_last (CNT_W'(chan_delay(IRQ_DELAY, g) - 1)),
      .o_pending    (w_pending[g])
    );
  end

endmodule
